// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-digit BCD up/down counter with built-in tick prescaler
// Wraps 0..MAX_BCD both ways with a Carry pulse; Load strobe overrides a coincident step.
module bcd_updown_counter #(
  parameter int                    DIGITS   = 2,
  parameter logic [4*DIGITS-1:0]   MAX_BCD  = 8'h99,
  parameter int                    TICK_DIV = 50_000_000
) (
  input  logic                  CLK,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadVal,
  output logic [4*DIGITS-1:0]   result,
  output logic                  Tick,
  output logic                  Carry,
  output logic                  LoadErr
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  result_q, result_d;
  logic          tick_q, tick_d;
  logic          carry_q, carry_d;
  logic          load_err_q, load_err_d;
  logic          load_ok;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic all_nibbles_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  always_comb begin
    pre_d      = pre_q;
    result_d   = result_q;
    tick_d     = 1'b0;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    load_ok    = all_nibbles_bcd(LoadVal) && (LoadVal <= MAX_BCD);

    // A rejected load still swallows any step due this cycle.
    if (Load) begin
      if (load_ok) begin
        result_d = LoadVal;
        pre_d    = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (En) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (Up) begin
          if (result_q == MAX_BCD) begin
            result_d = '0;
            carry_d  = 1'b1;
          end else begin
            result_d = bcd_inc(result_q);
          end
        end else begin
          if (result_q == '0) begin
            result_d = MAX_BCD;
            carry_d  = 1'b1;
          end else begin
            result_d = bcd_dec(result_q);
          end
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      pre_q      <= '0;
      result_q   <= '0;
      tick_q     <= 1'b0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      result_q   <= result_d;
      tick_q     <= tick_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign result  = result_q;
  assign Tick    = tick_q;
  assign Carry   = carry_q;
  assign LoadErr = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - directed bench for bcd_updown_counter
// Instance a uses MAX_BCD=99, instance b uses MAX_BCD=59; both share inputs, TICK_DIV=4.
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [7:0] load_val;
  logic [7:0] a_result, b_result;
  logic       a_tick, a_carry, a_load_err;
  logic       b_tick, b_carry, b_load_err;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h99), .TICK_DIV(4)) dut_a (
    .CLK(clk), .Rst(rst), .En(en), .Up(up), .Load(load), .LoadVal(load_val),
    .result(a_result), .Tick(a_tick), .Carry(a_carry), .LoadErr(a_load_err)
  );

  bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h59), .TICK_DIV(4)) dut_b (
    .CLK(clk), .Rst(rst), .En(en), .Up(up), .Load(load), .LoadVal(load_val),
    .result(b_result), .Tick(b_tick), .Carry(b_carry), .LoadErr(b_load_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // One full prescaler period on instance a, starting from pre==0.
  task automatic period_a(input string tag, input logic [7:0] exp_res, input logic exp_carry);
    for (int i = 1; i <= 4; i++) begin
      step();
      check({tag, "_tick"}, a_tick, (i == 4));
      check({tag, "_carry"}, a_carry, (i == 4) ? exp_carry : 1'b0);
    end
    check({tag, "_result"}, a_result, exp_res);
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 8'h00;
    step();
    step();
    check("rst_result", a_result, 8'h00);
    check("rst_tick", a_tick, 1'b0);
    check("rst_carry", a_carry, 1'b0);
    check("rst_loaderr", a_load_err, 1'b0);

    // 1: free-running count up, tick every 4th cycle
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      check("t1_tick", a_tick, (c % 4 == 0));
      check("t1_result", a_result, to_bcd(c / 4));
    end

    // 2: wrap up 99 -> 00
    do_load(8'h98);
    check("t2_load", a_result, 8'h98);
    check("t2_load_tick", a_tick, 1'b0);
    period_a("t2_a", 8'h99, 1'b0);
    period_a("t2_b", 8'h00, 1'b1);

    // 3: wrap down 00 -> 99, then borrow across digits
    up = 1'b0;
    period_a("t3_wrap", 8'h99, 1'b1);
    do_load(8'h10);
    period_a("t3_borrow", 8'h09, 1'b0);
    period_a("t3_dec", 8'h08, 1'b0);

    // 4: non-power-of-ten maximum on instance b
    up = 1'b1;
    do_load(8'h59);
    check("t4_b_load", b_result, 8'h59);
    check("t4_b_noerr", b_load_err, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t4_b_tick", b_tick, (i == 4));
    end
    check("t4_b_wrap", b_result, 8'h00);
    check("t4_b_carry", b_carry, 1'b1);
    check("t4_a_inc", a_result, 8'h60);
    en = 1'b0;
    do_load(8'h60);
    check("t4_b_err60", b_load_err, 1'b1);
    check("t4_b_keep60", b_result, 8'h00);
    check("t4_a_ok60", a_load_err, 1'b0);
    step();
    check("t4_b_errpulse", b_load_err, 1'b0);
    do_load(8'h3A);
    check("t4_b_err3a", b_load_err, 1'b1);
    check("t4_a_err3a", a_load_err, 1'b1);
    check("t4_a_keep3a", a_result, 8'h60);
    do_load(8'h00);
    en = 1'b1; up = 1'b0;
    period_a("t4_a_down", 8'h99, 1'b1);
    check("t4_b_down", b_result, 8'h59);
    check("t4_b_downcarry", b_carry, 1'b1);

    // 5: load on the tick cycle wins; En=0 freezes mid-period
    up = 1'b1;
    step(); step(); step();
    do_load(8'h42);
    check("t5_load_wins", a_result, 8'h42);
    check("t5_no_tick", a_tick, 1'b0);
    check("t5_no_carry", a_carry, 1'b0);
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_hold_tick", a_tick, 1'b0);
      check("t5_hold_result", a_result, 8'h42);
    end
    en = 1'b1;
    step();
    check("t5_resume_notick", a_tick, 1'b0);
    step();
    check("t5_resume_tick", a_tick, 1'b1);
    check("t5_resume_result", a_result, 8'h43);

    // 6: reset mid-period discards the partial prescaler count
    do_load(8'h47);
    step(); step();
    rst = 1'b1; load = 1'b1; load_val = 8'h55;
    step();
    rst = 1'b0; load = 1'b0;
    check("t6_rst_result", a_result, 8'h00);
    check("t6_rst_tick", a_tick, 1'b0);
    check("t6_rst_carry", a_carry, 1'b0);
    period_a("t6_first", 8'h01, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
